// File: rtl/telemetry_frame_formatter.sv
// telemetry_frame_formatter
//   Periodically snapshots encoder 1/2 positions, the raw DS18B20 temperature
//   and the bill-acceptor count, and serialises them as one fixed 18-character
//   frame "aEEE EEE TTTT BB\r\n" (uppercase hex), handing one byte at a time to
//   async_transmitter through its start/busy handshake.
//
//   Ports
//     CLK_10MHZ    system clock, rising edge
//     rst_n        asynchronous active-low reset
//     ena          enables the period timer and the start of new frames
//     frame_req    one-cycle request for an immediate frame
//     enc1Pos      encoder 1 position (12b)
//     enc2Pos      encoder 2 position (12b)
//     temperature  DS18B20 raw temperature (16b)
//     billAccumed  accumulated bill count (8b)
//     tx_busy      TxD_busy from async_transmitter
//     tx_start     one-cycle TxD_start pulse
//     tx_data      TxD_data, valid while tx_start=1
//     frame_busy   high from LOAD until the last byte has been accepted
//     frame_done   one-cycle pulse after the last byte's guard cycle
//     overrun      sticky flag: a trigger arrived while a frame was in flight
module telemetry_frame_formatter #(
    parameter int unsigned FRAME_PERIOD = 100000
) (
    input  logic        CLK_10MHZ,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        frame_req,
    input  logic [11:0] enc1Pos,
    input  logic [11:0] enc2Pos,
    input  logic [15:0] temperature,
    input  logic [7:0]  billAccumed,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int unsigned CNT_W    = $clog2(FRAME_PERIOD);
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned FRAME_LEN = 18;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GUARD,
        WAIT
    } stateType;

    stateType         state, stateNext;
    logic [CNT_W-1:0] periodCnt, periodCntNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [11:0]      enc1Snap, enc2Snap;
    logic [15:0]      tempSnap;
    logic [7:0]       billSnap;
    logic [7:0]       txDataNext;
    logic             frameBusyNext, frameDoneNext, overrunNext;
    logic             snapLoad;
    logic             trigP, trigger;
    logic [7:0]       idxChar;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'(nib) + 8'h30) : (8'(nib) + 8'h37);
    endfunction

    // Frame trigger: period expiry or an explicit request, both gated by ena.
    assign trigP   = ena && (periodCnt == LAST_CNT);
    assign trigger = trigP || (frame_req && ena);

    // Period counter runs only while enabled and wraps on expiry.
    always_comb begin
        periodCntNext = periodCnt;
        if (ena) begin
            periodCntNext = (periodCnt == LAST_CNT) ? '0 : periodCnt + CNT_W'(1);
        end
    end

    // Character at the current frame position, taken from the snapshot.
    always_comb begin
        idxChar = 8'h00;
        case (idx)
            5'd0:    idxChar = CHAR_A;
            5'd1:    idxChar = hexAscii(enc1Snap[11:8]);
            5'd2:    idxChar = hexAscii(enc1Snap[7:4]);
            5'd3:    idxChar = hexAscii(enc1Snap[3:0]);
            5'd4:    idxChar = CHAR_SPACE;
            5'd5:    idxChar = hexAscii(enc2Snap[11:8]);
            5'd6:    idxChar = hexAscii(enc2Snap[7:4]);
            5'd7:    idxChar = hexAscii(enc2Snap[3:0]);
            5'd8:    idxChar = CHAR_SPACE;
            5'd9:    idxChar = hexAscii(tempSnap[15:12]);
            5'd10:   idxChar = hexAscii(tempSnap[11:8]);
            5'd11:   idxChar = hexAscii(tempSnap[7:4]);
            5'd12:   idxChar = hexAscii(tempSnap[3:0]);
            5'd13:   idxChar = CHAR_SPACE;
            5'd14:   idxChar = hexAscii(billSnap[7:4]);
            5'd15:   idxChar = hexAscii(billSnap[3:0]);
            5'd16:   idxChar = CHAR_CR;
            5'd17:   idxChar = CHAR_LF;
            default: idxChar = 8'h00;
        endcase
    end

    // Next-state and output logic.
    // tx_data is loaded on entry to SEND so it is already stable when the
    // transmitter goes idle; tx_start is then issued in that same cycle, which
    // gives a trigger-to-first-start latency of two cycles.
    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        txDataNext    = tx_data;
        frameBusyNext = frame_busy;
        frameDoneNext = 1'b0;
        overrunNext   = overrun || (trigger && (state != IDLE));
        snapLoad      = 1'b0;
        tx_start      = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    stateNext     = LOAD;
                    frameBusyNext = 1'b1;
                end
            end
            LOAD: begin
                snapLoad   = 1'b1;
                idxNext    = '0;
                txDataNext = CHAR_A;
                stateNext  = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    stateNext = GUARD;
                end
            end
            GUARD: begin
                // The transmitter raises busy one cycle late, so skip it here.
                if (idx == LAST_IDX) begin
                    stateNext     = IDLE;
                    frameDoneNext = 1'b1;
                    frameBusyNext = 1'b0;
                end else begin
                    idxNext   = idx + IDX_W'(1);
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    stateNext  = SEND;
                    txDataNext = idxChar;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and registered outputs; snapshot captured only in LOAD.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            periodCnt  <= '0;
            idx        <= '0;
            enc1Snap   <= '0;
            enc2Snap   <= '0;
            tempSnap   <= '0;
            billSnap   <= '0;
            tx_data    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= stateNext;
            periodCnt  <= periodCntNext;
            idx        <= idxNext;
            tx_data    <= txDataNext;
            frame_busy <= frameBusyNext;
            frame_done <= frameDoneNext;
            overrun    <= overrunNext;
            if (snapLoad) begin
                enc1Snap <= enc1Pos;
                enc2Snap <= enc2Pos;
                tempSnap <= temperature;
                billSnap <= billAccumed;
            end
        end
    end

endmodule
